// File: rtl/seq_detect_param_if.sv
// Serial-bit bus for seq_detect_param: enable, flush, data bit, match flag and
// optional match count (present only when SEQ_DET_CNT_EN is defined).
interface seq_detect_param_if #(
   parameter int CNT_W = 8
);
   logic en;
   logic clr;
   logic x;
   logic y;
`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] match_cnt;

   modport master (output en, output clr, output x, input y, input match_cnt);
   modport slave  (input en, input clr, input x, output y, output match_cnt);
`else
   modport master (output en, output clr, output x, input y);
   modport slave  (input en, input clr, input x, output y);
`endif
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with a Mealy match flag.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
module seq_detect_param #(
   parameter int             LEN     = 5,
   parameter logic [LEN-1:0] PATTERN = 5'b11011,
   parameter bit             OVERLAP = 1'b1,
   parameter int             CNT_W   = 8
) (
   input logic               clk,
   input logic               rst,
   seq_detect_param_if.slave bus
);

   localparam int             FILL_W   = (LEN > 2) ? $clog2(LEN) : 1;
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);

   typedef enum logic {
      FILLING = 1'b0,
      ARMED   = 1'b1
   } state_t;

   state_t             state;
   logic [FILL_W-1:0]  fill;
   logic [LEN-2:0]     hist;
   logic [LEN-1:0]     window;
   logic               match;
   logic               take;

   // The incoming bit joins the history as the LSB; the MSB of the window is the oldest bit.
   assign window = {hist, bus.x};
   assign match  = (state == ARMED) && (window == PATTERN);
   assign take   = bus.en & ~bus.clr & ~rst;
   assign bus.y  = take & match;

   always_ff @(posedge clk) begin
      if (rst || bus.clr) begin
         state <= FILLING;
         fill  <= '0;
         hist  <= '0;
      end else if (bus.en) begin
         hist <= window[LEN-2:0];
         if (state == FILLING) begin
            fill <= fill + 1'b1;
            if (fill + 1'b1 == FILL_MAX) begin
               state <= ARMED;
            end
         end else if (match && !OVERLAP) begin
            // Stale bits remain in hist; fill decides when they count again.
            state <= FILLING;
            fill  <= '0;
         end
      end
   end

`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (bus.y && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bus.match_cnt = cnt;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised and directed bench for seq_detect_param across several LEN/PATTERN/OVERLAP
// configurations, all driven from one shared serial stream and checked against a bit-history model.
module tb_seq_detect_param;

   localparam int NC = 6;
   localparam int          LENS [NC] = '{5, 5, 2, 7, 32, 2};
   localparam logic [31:0] PATS [NC] = '{32'h1B, 32'h1B, 32'h3, 32'h59, 32'hA5C30F96, 32'h2};
   localparam bit          OVS  [NC] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam int          CWS  [NC] = '{8, 8, 2, 8, 8, 8};

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic clr;
   logic x;
   logic [NC-1:0] y_all;
   logic [7:0]    cnt_all [NC];

   int checks = 0;
   int errors = 0;

   // Reference state: all accepted bits as a shift value plus the number accepted since the last restart.
   longint unsigned m_hist [NC];
   int              m_seen [NC];
   int              m_cnt  [NC];
   int              pulses [NC];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NC; g++) begin : gen_dut
      seq_detect_param_if #(.CNT_W(CWS[g])) bus ();

      assign bus.en  = en;
      assign bus.clr = clr;
      assign bus.x   = x;
      assign y_all[g] = bus.y;
`ifdef SEQ_DET_CNT_EN
      assign cnt_all[g] = 8'(bus.match_cnt);
`else
      assign cnt_all[g] = 8'd0;
`endif

      seq_detect_param #(
         .LEN     (LENS[g]),
         .PATTERN (PATS[g][LENS[g]-1:0]),
         .OVERLAP (OVS[g]),
         .CNT_W   (CWS[g])
      ) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         if (errors <= 40) $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic bit model_match(int k, bit xb);
      longint unsigned mask;
      longint unsigned win;
      mask = (64'd1 << LENS[k]) - 64'd1;
      win  = ((m_hist[k] << 1) | longint'(xb)) & mask;
      return (m_seen[k] >= LENS[k] - 1) && (win == longint'(PATS[k]) & mask);
   endfunction

   // One clock: drive, compare combinational y at the falling edge, then advance the model.
   task automatic step(input bit e, input bit c, input bit xi, input bit r);
      bit ey [NC];
      rst = r; en = e; clr = c; x = xi;
      @(negedge clk);
      for (int k = 0; k < NC; k++) begin
         ey[k] = e && !c && !r && model_match(k, xi);
         chk($sformatf("y_cfg%0d", k), 64'(y_all[k]), 64'(ey[k]));
`ifdef SEQ_DET_CNT_EN
         chk($sformatf("cnt_cfg%0d", k), 64'(cnt_all[k]), 64'(m_cnt[k]));
`endif
         if (y_all[k] === 1'b1) pulses[k]++;
      end
      @(posedge clk);
      for (int k = 0; k < NC; k++) begin
         if (r) begin
            m_hist[k] = 0; m_seen[k] = 0; m_cnt[k] = 0;
         end else if (c) begin
            m_hist[k] = 0; m_seen[k] = 0;
         end else if (e) begin
            m_hist[k] = (m_hist[k] << 1) | longint'(xi);
            if (ey[k] && !OVS[k]) m_seen[k] = 0;
            else if (m_seen[k] < 1000) m_seen[k]++;
            if (ey[k] && m_cnt[k] < (1 << CWS[k]) - 1) m_cnt[k]++;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < NC; k++) pulses[k] = 0;
   endtask

   initial begin
      bit s1 [11] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
      bit s4 [4]  = '{1, 1, 0, 1};
      int inj;
      logic [7:0] cnt_hold;
      for (int k = 0; k < NC; k++) begin
         m_hist[k] = 0; m_seen[k] = 0; m_cnt[k] = 0; pulses[k] = 0;
      end
      rst = 1'b1; en = 1'b0; clr = 1'b0; x = 1'b0;
      @(posedge clk); #1;
      do_reset();
`ifdef SEQ_DET_CNT_EN
      chk("cnt_after_reset", 64'(cnt_all[0]), 64'd0);
`endif

      // Overlapping vs non-overlapping on 11011 followed by 011.
      for (int i = 0; i < 11; i++) begin
         step(1'b1, 1'b0, s1[i], 1'b0);
         if (i == 7) begin
            chk("ovl_pulses_8", 64'(pulses[0]), 64'd2);
            chk("novl_pulses_8", 64'(pulses[1]), 64'd1);
`ifdef SEQ_DET_CNT_EN
            chk("ovl_cnt_8", 64'(cnt_all[0]), 64'd2);
`endif
         end
      end
      chk("novl_pulses_11", 64'(pulses[1]), 64'd2);
`ifdef SEQ_DET_CNT_EN
      chk("novl_cnt_11", 64'(cnt_all[1]), 64'd2);
`endif

      // Reset mid-pattern discards the partial history.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, s4[i], 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("rst_mid_pulses", 64'(pulses[0]), 64'd0);

      // Flush mid-pattern: same outcome, counter retained.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, s1[i], 1'b0);
      cnt_hold = cnt_all[0];
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, s4[i], 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("clr_mid_pulses", 64'(pulses[0]), 64'd1);
      chk("clr_keeps_cnt", 64'(cnt_all[0]), 64'(cnt_hold));

      // Enable gaps with a toggling data bit.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, s4[i], 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'((i + 1) % 2), 1'b0);
      chk("en_gap_quiet", 64'(pulses[0]), 64'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("en_gap_pulses", 64'(pulses[0]), 64'd1);

      // Constant ones on the LEN=2 pattern 11 with a 2-bit counter.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("len2_pulses", 64'(pulses[2]), 64'd7);
`ifdef SEQ_DET_CNT_EN
      chk("len2_cnt_sat", 64'(cnt_all[2]), 64'd3);
`endif

      // Random stream with occasional injections of the 32-bit pattern.
      do_reset();
      inj = -1;
      for (int n = 0; n < 10000; n++) begin
         bit e, c, r, xi;
         e  = ($urandom_range(0, 9) != 0);
         c  = ($urandom_range(0, 49) == 0);
         r  = ($urandom_range(0, 199) == 0);
         xi = 1'($urandom_range(0, 1));
         if (inj < 0 && $urandom_range(0, 149) == 0) inj = 31;
         if (inj >= 0) begin
            logic [31:0] p4;
            p4 = PATS[4];
            xi = p4[inj]; e = 1'b1; c = 1'b0; r = 1'b0;
            inj--;
         end
         step(e, c, xi, r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
